// File: rtl/microseq_stack.sv
// Microprogram sequencer slice: next-address select with OR mask and zero-force,
// PC incrementer, address register and a count-based return-address LIFO.
module microseq_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             hold,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] rin,
  input  logic [WIDTH-1:0] orin,
  input  logic [1:0]       sel,
  input  logic             zero_n,
  input  logic             cin,
  input  logic             re_n,
  input  logic             fe_n,
  input  logic             pup,
  output logic [WIDTH-1:0] yout,
  output logic             cout,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_ovf,
  output logic             stack_unf,
  output logic [CW-1:0]    depth_count
);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] ar_r;
  logic [WIDTH-1:0] stack_r [DEPTH];
  logic [CW-1:0]    count_r;
  logic             ovf_r;
  logic             unf_r;

  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] mux_s;
  logic [WIDTH-1:0] yout_s;
  logic [WIDTH-1:0] pc_next_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign push_s    = ~fe_n & pup;
  assign pop_s     = ~fe_n & ~pup;
  assign pc_next_s = yout_s + {{(WIDTH-1){1'b0}}, cin};

  // Top of stack is the entry just below the count; reads as zero when empty.
  always_comb begin
    top_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      top_s = (count_r == CW'(i + 1)) ? stack_r[i] : top_s;
    end
  end

  // Next-address source select, then OR mask and zero-force.
  always_comb begin
    mux_s = {WIDTH{1'b0}};
    case (sel)
      2'd0:    mux_s = pc_r;
      2'd1:    mux_s = ar_r;
      2'd2:    mux_s = top_s;
      2'd3:    mux_s = din;
      default: mux_s = din;
    endcase
    if (zero_n) begin
      yout_s = mux_s | orin;
    end else begin
      yout_s = {WIDTH{1'b0}};
    end
  end

  // State update: reset dominates hold; pushes store the current PC as return address.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_r    <= {WIDTH{1'b0}};
      ar_r    <= {WIDTH{1'b0}};
      count_r <= {CW{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= {WIDTH{1'b0}};
      end
    end else if (!hold) begin
      pc_r <= pc_next_s;
      if (!re_n) begin
        ar_r <= rin;
      end
      if (push_s) begin
        if (full_s) begin
          ovf_r <= 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (count_r == CW'(i)) begin
              stack_r[i] <= pc_r;
            end
          end
          count_r <= count_r + CW'(1);
        end
      end else if (pop_s) begin
        if (empty_s) begin
          unf_r <= 1'b1;
        end else begin
          count_r <= count_r - CW'(1);
        end
      end
    end
  end

  assign yout        = yout_s;
  assign cout        = cin & (&yout_s);
  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign stack_ovf   = ovf_r;
  assign stack_unf   = unf_r;
  assign depth_count = count_r;

endmodule

// File: tb/tb_microseq_stack.sv
// Bench for microseq_stack: abstract array/integer model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_microseq_stack;
  localparam int W  = 12;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          reset_n, hold, zero_n, cin, re_n, fe_n, pup;
  logic [W-1:0]  din, rin, orin;
  logic [1:0]    sel;
  logic [W-1:0]  yout;
  logic          cout, stack_full, stack_empty, stack_ovf, stack_unf;
  logic [CW-1:0] depth_count;

  int checks = 0;
  int errors = 0;

  int m_pc = 0, m_ar = 0, m_cnt = 0;
  int m_stk [D];
  bit m_ovf = 1'b0, m_unf = 1'b0, m_valid = 1'b0;

  microseq_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .hold(hold), .din(din), .rin(rin),
    .orin(orin), .sel(sel), .zero_n(zero_n), .cin(cin), .re_n(re_n),
    .fe_n(fe_n), .pup(pup), .yout(yout), .cout(cout),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf), .depth_count(depth_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_y();
    int m;
    case (sel)
      2'd0:    m = m_pc;
      2'd1:    m = m_ar;
      2'd2:    m = (m_cnt == 0) ? 0 : m_stk[m_cnt - 1];
      default: m = int'(din);
    endcase
    return zero_n ? (m | int'(orin)) : 0;
  endfunction

  // Reference model: advances on each rising edge from the sampled inputs.
  always @(posedge clock) begin
    if (!reset_n) begin
      m_pc <= 0; m_ar <= 0; m_cnt <= 0; m_ovf <= 1'b0; m_unf <= 1'b0; m_valid <= 1'b1;
      for (int i = 0; i < D; i++) m_stk[i] <= 0;
    end else if (m_valid && !hold) begin
      m_pc <= (exp_y() + int'(cin)) % (1 << W);
      if (!re_n) m_ar <= int'(rin);
      if (!fe_n && pup) begin
        if (m_cnt == D) m_ovf <= 1'b1;
        else begin
          m_stk[m_cnt] <= m_pc;
          m_cnt <= m_cnt + 1;
        end
      end else if (!fe_n && !pup) begin
        if (m_cnt == 0) m_unf <= 1'b1;
        else m_cnt <= m_cnt - 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("m_yout",  32'(yout), 32'(exp_y()));
      chk("m_cout",  32'(cout), 32'(cin && exp_y() == (1 << W) - 1));
      chk("m_full",  32'(stack_full), 32'(m_cnt == D));
      chk("m_empty", 32'(stack_empty), 32'(m_cnt == 0));
      chk("m_ovf",   32'(stack_ovf), 32'(m_ovf));
      chk("m_unf",   32'(stack_unf), 32'(m_unf));
      chk("m_depth", 32'(depth_count), 32'(m_cnt));
    end
  end

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    hold = 1'b0; din = '0; rin = '0; orin = '0; sel = 2'd0;
    zero_n = 1'b1; cin = 1'b0; re_n = 1'b1; fe_n = 1'b1; pup = 1'b0;
  endtask

  initial begin
    logic [W-1:0] tops [4];
    tops[0] = 12'h013; tops[1] = 12'h012; tops[2] = 12'h011; tops[3] = 12'h010;
    idle();
    reset_n = 1'b0;
    edge1();
    reset_n = 1'b1;
    #1;
    chk("rst_depth", 32'(depth_count), 32'd0);
    chk("rst_empty", 32'(stack_empty), 32'd1);
    chk("rst_full",  32'(stack_full), 32'd0);
    chk("rst_flags", 32'({stack_ovf, stack_unf}), 32'd0);
    chk("rst_yout",  32'(yout), 32'h000);

    // PC counts up from zero
    cin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 chk("pc_seq", 32'(yout), 32'(k));
      edge1();
    end

    // Call/return around 0x3FF
    sel = 2'd3; din = 12'h3FE; edge1();
    din = 12'h120; fe_n = 1'b0; pup = 1'b1;
    #1 chk("call_y", 32'(yout), 32'h120);
    edge1();
    chk("call_depth", 32'(depth_count), 32'd1);
    sel = 2'd2; pup = 1'b0;
    #1 chk("ret_y", 32'(yout), 32'h3FF);
    edge1();
    sel = 2'd0; cin = 1'b0; fe_n = 1'b1;
    #1 chk("ret_pc", 32'(yout), 32'h400);
    chk("ret_depth", 32'(depth_count), 32'd0);

    // Fill, overflow, drain
    sel = 2'd3; din = 12'h00F; cin = 1'b1; edge1();
    sel = 2'd0; fe_n = 1'b0; pup = 1'b1;
    for (int k = 0; k < 4; k++) edge1();
    chk("fill_full", 32'(stack_full), 32'd1);
    chk("fill_depth", 32'(depth_count), 32'd4);
    edge1();
    fe_n = 1'b1; sel = 2'd2;
    #1 chk("ovf_top", 32'(yout), 32'h013);
    chk("ovf_flag", 32'(stack_ovf), 32'd1);
    chk("ovf_depth", 32'(depth_count), 32'd4);
    cin = 1'b0; fe_n = 1'b0; pup = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("pop_top", 32'(yout), 32'(tops[k]));
      edge1();
    end
    chk("drain_empty", 32'(stack_empty), 32'd1);
    chk("drain_ovf", 32'(stack_ovf), 32'd1);

    // Underflow, then OR mask over an empty top
    sel = 2'd0; edge1();
    chk("unf_flag", 32'(stack_unf), 32'd1);
    chk("unf_depth", 32'(depth_count), 32'd0);
    fe_n = 1'b1; sel = 2'd2; orin = 12'h005;
    #1 chk("unf_orin", 32'(yout), 32'h005);

    // Hold freezes everything, release applies AR load and push together
    orin = '0; sel = 2'd0; cin = 1'b1; hold = 1'b1;
    re_n = 1'b0; rin = 12'hABC; fe_n = 1'b0; pup = 1'b1;
    #1 chk("hold_pc", 32'(yout), 32'h010);
    edge1();
    chk("hold_depth", 32'(depth_count), 32'd0);
    sel = 2'd1;
    #1 chk("hold_ar", 32'(yout), 32'h000);
    hold = 1'b0; sel = 2'd0;
    edge1();
    re_n = 1'b1; fe_n = 1'b1; sel = 2'd1;
    #1 chk("rel_ar", 32'(yout), 32'hABC);
    chk("rel_depth", 32'(depth_count), 32'd1);
    sel = 2'd2;
    #1 chk("rel_top", 32'(yout), 32'h010);

    // PC wrap and zero-force
    sel = 2'd3; din = 12'hFFE; edge1();
    sel = 2'd0;
    #1 chk("wrap_y", 32'(yout), 32'hFFF);
    chk("wrap_cout", 32'(cout), 32'd1);
    edge1();
    cin = 1'b0;
    #1 chk("wrap_pc", 32'(yout), 32'h000);
    zero_n = 1'b0; cin = 1'b1; orin = 12'hFFF;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1 chk("zero_y", 32'({cout, yout}), 32'h0);
    end

    // Reset overrides hold
    idle();
    hold = 1'b1; reset_n = 1'b0;
    edge1();
    reset_n = 1'b1; hold = 1'b0; sel = 2'd1;
    #1 chk("rst2_ar", 32'(yout), 32'h000);
    chk("rst2_state", 32'({stack_ovf, stack_unf, 3'(depth_count)}), 32'h0);

    // Mixed traffic checked by the model
    for (int k = 0; k < 60; k++) begin
      hold = ($urandom_range(0, 7) == 0); din = W'($urandom); rin = W'($urandom);
      orin = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      sel = 2'($urandom); zero_n = ($urandom_range(0, 7) != 0); cin = 1'($urandom);
      re_n = 1'($urandom); fe_n = 1'($urandom); pup = 1'($urandom);
      edge1();
    end

    idle();
    edge1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
